tiny_fpga_cfg_sequencer: RTL and testbench
==========================================

Name: tiny_fpga_cfg_sequencer

Overview:
- Sequences configuration and start-up of the tiny FPGA fabric.
- Accepts a byte-wide bitstream from the host/loader over AXI-stream and serialises it LSB-first onto the fabric's 1-bit configuration stream, with `tlast` on the final bit.
- Holds `cfg` high for the whole load, waits for the fabric's `cfg_ready`, then asserts `run`.
- Reports busy, done and error status to the host.

Parameters:
- BITSTREAM_BITS, 144, total configuration bits the fabric expects (>= 2).
- IN_WIDTH, 8, host stream data width in bits.
- READY_TIMEOUT, 255, maximum cycles to wait for `cfg_ready` after the last bit is accepted.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  pulse; begins a load when in IDLE, ignored in all other states
- stop  in  1  in RUN, drops `run` and returns to IDLE
- clear  in  1  in ERR, returns to IDLE
- s_tvalid  in  1  host stream valid
- s_tready  out  1  host stream ready
- s_tdata  in  IN_WIDTH  host bitstream word, LSB sent first
- s_tlast  in  1  marks the final host word
- m_tvalid  out  1  fabric cfg stream valid
- m_tready  in  1  fabric cfg stream ready
- m_tdata  out  1  serial config bit
- m_tlast  out  1  high on bit BITSTREAM_BITS-1
- cfg  out  1  fabric configure enable
- cfg_ready  in  1  fabric reports configuration complete
- run  out  1  fabric run enable
- busy  out  1  high in LOAD and WAIT
- done  out  1  high in RUN
- err  out  1  high in ERR

Behaviour:
- Clock and reset: one clock `clk`; `rst_n` is asynchronous, active-low.
- Reset (including mid-load): state IDLE; bit counter, shift register and timeout counter cleared. All outputs 0: `s_tready`, `m_tvalid`, `m_tdata`, `m_tlast`, `cfg`, `run`, `busy`, `done`, `err`.
- FSM states: IDLE, LOAD, WAIT, RUN, ERR. All outputs are registered or decoded from the state and registers.
- IDLE -> LOAD: on `start`. `cfg` goes high the cycle after `start`.
- LOAD, shift register:
  - `s_tready` = 1 only when the shift register is empty.
  - An `s_tvalid & s_tready` transfer loads `s_tdata` and sets the valid-bit count to min(IN_WIDTH, bits remaining).
  - `m_tvalid` = 1 while valid bits remain.
  - `m_tdata` = shift register bit 0.
  - Each `m_tvalid & m_tready` transfer shifts right by one and increments the global bit counter.
  - No bubble-free requirement: one idle output cycle between words is allowed.
- LOAD, `m_tlast`: `m_tlast` = (bit counter == BITSTREAM_BITS-1) & `m_tvalid`.
- LOAD, partial final word: when BITSTREAM_BITS mod IN_WIDTH != 0, the unused upper bits of the final word are discarded, never sent.
- LOAD, `s_tlast` framing:
  - `s_tlast` on a word that is not the final word -> ERR, word discarded.
  - Final word accepted with `s_tlast` = 0 -> ERR.
  - ERR is entered the cycle after the offending transfer; `m_tvalid` drops immediately.
- LOAD -> WAIT: on the `m_tlast` handshake. `cfg` stays 1 and the timeout counter clears.
- WAIT:
  - `cfg_ready` = 1 -> RUN next cycle: `cfg` = 0, `run` = 1, `done` = 1.
  - Timeout counter reaches READY_TIMEOUT without `cfg_ready` -> ERR.
  - `cfg_ready` and timeout in the same cycle: `cfg_ready` wins.
- RUN:
  - `stop` -> IDLE (`run`, `done` = 0 next cycle).
  - `start` and `stop` in the same cycle: `stop` wins; `start` is ignored.
- ERR:
  - `err` = 1, `cfg` = 0, `run` = 0, `s_tready` = 0.
  - `clear` -> IDLE.
- Ignored inputs: `start`, `stop` and `clear` have no effect outside the states listed above.
- Counter widths: bit counter is $clog2(BITSTREAM_BITS+1) bits; timeout counter is $clog2(READY_TIMEOUT+1) bits. Neither wraps: both saturate/clear as described.

Optional Feature:
- Macro: TINY_FPGA_CFG_CRC_EN.
- Defined:
  - A CRC-8 (poly 0x07, init 0x00, MSB-first shift) is updated with every bit on an `m_tdata` handshake.
  - After the final config word, LOAD expects exactly one extra host word. Its low 8 bits are the expected CRC and it must carry `s_tlast`; it is not forwarded to the fabric.
  - `s_tlast` is therefore required on that CRC word, not on the final config word. `s_tlast` on the final config word -> ERR.
  - Match -> WAIT. Mismatch or missing `s_tlast` -> ERR.
  - Output port `crc_err` (1 bit) distinguishes a CRC failure inside ERR.
- Undefined: no CRC logic, no extra word, no `crc_err` port.

Test Plan (BITSTREAM_BITS=20, IN_WIDTH=8, READY_TIMEOUT=15):
- Nominal load:
  - Stimulus: `start`; words 0xA5, 0x3C, 0x0F (`s_tlast` on third); `m_tready`=1; `cfg_ready` 3 cycles after the last bit.
  - Required: 20 bits in order 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,1,1,1; `m_tlast` only on bit 19; `cfg` 1 throughout; then `run`=`done`=1, `cfg`=0.
- Backpressure:
  - Stimulus: same load with `m_tready` toggling 1,0,1,0.
  - Required: identical bit sequence; no bit duplicated or dropped; `s_tready`=0 while bits remain.
- Framing errors:
  - `s_tlast` on word 2 -> `err`=1, `cfg`=0.
  - 3rd word without `s_tlast` -> `err`=1.
  - Both cases: `clear` -> IDLE, all outputs 0.
- Timeout:
  - `cfg_ready` held 0 -> `err` rises 15 cycles after the last bit.
  - `cfg_ready` rising on the timeout cycle itself -> RUN.
- Asynchronous reset:
  - Stimulus: assert `rst_n`=0 after 9 bits sent.
  - Required: all outputs 0 immediately; a fresh `start` and load then completes normally.
- Run control: in RUN, assert `stop` and `start` together -> IDLE, `run`=0; `start` in RUN alone is ignored.

Source files
------------

// File: rtl/tiny_fpga_cfg_sequencer_if.sv
// Host byte stream and fabric serial config stream seen by the tiny FPGA config sequencer.
// master = the sequencer (consumes s_*, produces m_*); slave = host/fabric environment.
interface tiny_fpga_cfg_sequencer_if #(
  parameter int IN_WIDTH = 8
);
  logic                s_tvalid;
  logic                s_tready;
  logic [IN_WIDTH-1:0] s_tdata;
  logic                s_tlast;
  logic                m_tvalid;
  logic                m_tready;
  logic                m_tdata;
  logic                m_tlast;

  modport master (
    input  s_tvalid, s_tdata, s_tlast, m_tready,
    output s_tready, m_tvalid, m_tdata, m_tlast
  );

  modport slave (
    output s_tvalid, s_tdata, s_tlast, m_tready,
    input  s_tready, m_tvalid, m_tdata, m_tlast
  );
endinterface

// File: rtl/tiny_fpga_cfg_sequencer.sv
// Loads a host bitstream LSB-first onto the fabric config stream, then waits for cfg_ready and runs.
// Optional CRC-8 trailer check when TINY_FPGA_CFG_CRC_EN is defined (adds crc_err output).
module tiny_fpga_cfg_sequencer #(
  parameter int BITSTREAM_BITS = 144,
  parameter int IN_WIDTH       = 8,
  parameter int READY_TIMEOUT  = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic stop,
  input  logic clear,
  output logic cfg,
  input  logic cfg_ready,
  output logic run,
  output logic busy,
  output logic done,
  output logic err,
`ifdef TINY_FPGA_CFG_CRC_EN
  output logic crc_err,
`endif
  tiny_fpga_cfg_sequencer_if.master bus
);

  localparam int BCW = $clog2(BITSTREAM_BITS + 1);
  localparam int VCW = $clog2(IN_WIDTH + 1);
  localparam int TCW = $clog2(READY_TIMEOUT + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(BITSTREAM_BITS - 1);
  localparam logic [TCW-1:0] TO_LAST  = TCW'(READY_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT, RUN, ERR} state_t;

  state_t              state;
  logic [IN_WIDTH-1:0] shreg;
  logic [VCW-1:0]      vcnt;
  logic [BCW-1:0]      bit_cnt;
  logic [TCW-1:0]      tcnt;
  logic                in_hs;
  logic                out_hs;

  // Valid bits carried by the next host word: a full word, or whatever remains of the bitstream.
  function automatic logic [VCW-1:0] word_bits(input logic [BCW-1:0] sent);
    int rem;
    rem = BITSTREAM_BITS - int'(sent);
    return (rem >= IN_WIDTH) ? VCW'(IN_WIDTH) : VCW'(rem);
  endfunction

`ifdef TINY_FPGA_CFG_CRC_EN
  localparam logic [BCW-1:0] ALL_BITS = BCW'(BITSTREAM_BITS);

  logic [7:0] crc;
  logic [7:0] crc_word;

  // CRC-8, poly 0x07, one bit per step, MSB-first register shift.
  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  assign crc_word = 8'(bus.s_tdata);
`else
  function automatic logic is_final_word(input logic [BCW-1:0] sent);
    int rem;
    rem = BITSTREAM_BITS - int'(sent);
    return rem <= IN_WIDTH;
  endfunction
`endif

  assign bus.s_tready = (state == LOAD) && (vcnt == '0);
  assign bus.m_tvalid = (state == LOAD) && (vcnt != '0);
  assign bus.m_tdata  = bus.m_tvalid & shreg[0];
  assign bus.m_tlast  = bus.m_tvalid && (bit_cnt == LAST_BIT);
  assign in_hs        = bus.s_tvalid & bus.s_tready;
  assign out_hs       = bus.m_tvalid & bus.m_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      vcnt    <= '0;
      bit_cnt <= '0;
      tcnt    <= '0;
      cfg     <= 1'b0;
      run     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
`ifdef TINY_FPGA_CFG_CRC_EN
      crc     <= '0;
      crc_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= LOAD;
            cfg     <= 1'b1;
            busy    <= 1'b1;
            shreg   <= '0;
            vcnt    <= '0;
            bit_cnt <= '0;
            tcnt    <= '0;
`ifdef TINY_FPGA_CFG_CRC_EN
            crc     <= '0;
            crc_err <= 1'b0;
`endif
          end
        end

        LOAD: begin
          // Input and output handshakes are mutually exclusive: s_tready needs an empty register.
          if (out_hs) begin
            shreg   <= shreg >> 1;
            vcnt    <= vcnt - 1'b1;
            bit_cnt <= bit_cnt + 1'b1;
`ifdef TINY_FPGA_CFG_CRC_EN
            crc     <= crc8_step(crc, shreg[0]);
`else
            if (bit_cnt == LAST_BIT) begin
              state <= WAIT;
              tcnt  <= '0;
            end
`endif
          end else if (in_hs) begin
`ifdef TINY_FPGA_CFG_CRC_EN
            if (bit_cnt == ALL_BITS) begin
              // Trailer word: expected CRC over every bit sent, must close the frame.
              if (bus.s_tlast && (crc_word == crc)) begin
                state <= WAIT;
                tcnt  <= '0;
              end else begin
                state   <= ERR;
                cfg     <= 1'b0;
                busy    <= 1'b0;
                err     <= 1'b1;
                crc_err <= (crc_word != crc);
              end
            end else if (bus.s_tlast) begin
              state <= ERR;
              cfg   <= 1'b0;
              busy  <= 1'b0;
              err   <= 1'b1;
            end else begin
              shreg <= bus.s_tdata;
              vcnt  <= word_bits(bit_cnt);
            end
`else
            // Framing must agree: s_tlast exactly on the word that completes the bitstream.
            if (bus.s_tlast != is_final_word(bit_cnt)) begin
              state <= ERR;
              cfg   <= 1'b0;
              busy  <= 1'b0;
              err   <= 1'b1;
            end else begin
              shreg <= bus.s_tdata;
              vcnt  <= word_bits(bit_cnt);
            end
`endif
          end
        end

        WAIT: begin
          if (cfg_ready) begin
            state <= RUN;
            cfg   <= 1'b0;
            busy  <= 1'b0;
            run   <= 1'b1;
            done  <= 1'b1;
          end else if (tcnt == TO_LAST) begin
            state <= ERR;
            cfg   <= 1'b0;
            busy  <= 1'b0;
            err   <= 1'b1;
            tcnt  <= tcnt + 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        RUN: begin
          if (stop) begin
            state <= IDLE;
            run   <= 1'b0;
            done  <= 1'b0;
          end
        end

        ERR: begin
          if (clear) begin
            state   <= IDLE;
            err     <= 1'b0;
`ifdef TINY_FPGA_CFG_CRC_EN
            crc_err <= 1'b0;
`endif
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tiny_fpga_cfg_sequencer.sv
// Directed bench for tiny_fpga_cfg_sequencer (20-bit bitstream, byte input, timeout 15).
// Expected serial bits are queued on word acceptance and checked by an independent monitor.
module tb_tiny_fpga_cfg_sequencer;
  localparam int BITS = 20;
  localparam int INW  = 8;
  localparam int TO   = 15;

  logic clk       = 1'b0;
  logic rst_n     = 1'b0;
  logic start     = 1'b0;
  logic stop      = 1'b0;
  logic clear     = 1'b0;
  logic cfg_ready = 1'b0;
  logic cfg, run, busy, done, err;

  tiny_fpga_cfg_sequencer_if #(.IN_WIDTH(INW)) bus_if ();

  tiny_fpga_cfg_sequencer #(
    .BITSTREAM_BITS(BITS),
    .IN_WIDTH      (INW),
    .READY_TIMEOUT (TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .cfg      (cfg),
    .cfg_ready(cfg_ready),
    .run      (run),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .bus      (bus_if)
  );

  typedef struct packed {
    logic d;
    logic l;
  } exp_t;

  exp_t sb[$];
  int   checks    = 0;
  int   errors    = 0;
  int   bits_seen = 0;
  bit   bp_mode   = 1'b0;

  // 0xA5, 0x3C, low nibble of 0x0F, each LSB first.
  bit         exp_bits [20] = '{1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,1,1,1};
  logic [7:0] words    [3]  = '{8'hA5, 8'h3C, 8'h0F};

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic check_n(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_cfg"},      cfg,             1'b0);
    check({tag, "_run"},      run,             1'b0);
    check({tag, "_busy"},     busy,            1'b0);
    check({tag, "_done"},     done,            1'b0);
    check({tag, "_err"},      err,             1'b0);
    check({tag, "_s_tready"}, bus_if.s_tready, 1'b0);
    check({tag, "_m_tvalid"}, bus_if.m_tvalid, 1'b0);
    check({tag, "_m_tdata"},  bus_if.m_tdata,  1'b0);
    check({tag, "_m_tlast"},  bus_if.m_tlast,  1'b0);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_cfg",  cfg,  1'b1);
    check("start_busy", busy, 1'b1);
  endtask

  // Offer word idx; when the DUT is expected to keep it, queue its serial bits.
  task automatic send_word(input int idx, input logic last, input bit keep);
    int   n;
    exp_t e;
    n = 0;
    bus_if.s_tdata  = words[idx];
    bus_if.s_tlast  = last;
    bus_if.s_tvalid = 1'b1;
    @(negedge clk);
    while (bus_if.s_tready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("s_tready_wait", bus_if.s_tready, 1'b1);
    if (keep) begin
      for (int b = idx * INW; b < idx * INW + INW && b < BITS; b++) begin
        e.d = exp_bits[b];
        e.l = (b == BITS - 1);
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    bus_if.s_tvalid = 1'b0;
    bus_if.s_tlast  = 1'b0;
  endtask

  task automatic load_all();
    send_word(0, 1'b0, 1'b1);
    send_word(1, 1'b0, 1'b1);
    send_word(2, 1'b1, 1'b1);
  endtask

  // Returns just after the edge that accepts the final bit.
  task automatic wait_last();
    int n;
    n = 0;
    @(negedge clk);
    while (!(bus_if.m_tvalid === 1'b1 && bus_if.m_tready === 1'b1 && bus_if.m_tlast === 1'b1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("last_bit_seen", bus_if.m_tlast, 1'b1);
    tick();
  endtask

  initial begin : drive_tready
    bus_if.m_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus_if.m_tready = bp_mode ? ~bus_if.m_tready : 1'b1;
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus_if.m_tvalid === 1'b1 && bus_if.m_tready === 1'b1) begin
        bits_seen++;
        if (sb.size() == 0) begin
          check("unexpected_bit", bus_if.m_tvalid, 1'b0);
        end else begin
          e = sb.pop_front();
          check("m_tdata", bus_if.m_tdata, e.d);
          check("m_tlast", bus_if.m_tlast, e.l);
        end
        check("cfg_during_load", cfg, 1'b1);
      end
      if (bus_if.m_tvalid === 1'b1) check("s_tready_while_bits", bus_if.s_tready, 1'b0);
      else                          check("m_tlast_without_valid", bus_if.m_tlast, 1'b0);
    end
  end

  initial begin : stimulus
    int base;
    int n;
    bus_if.s_tvalid = 1'b0;
    bus_if.s_tdata  = '0;
    bus_if.s_tlast  = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    rst_n = 1'b1;
    tick();

    // Nominal load, cfg_ready three cycles after the final bit
    do_start();
    load_all();
    wait_last();
    check("wait_cfg",  cfg,  1'b1);
    check("wait_busy", busy, 1'b1);
    repeat (2) tick();
    cfg_ready = 1'b1;
    tick();
    cfg_ready = 1'b0;
    check("nom_run",  run,  1'b1);
    check("nom_done", done, 1'b1);
    check("nom_cfg",  cfg,  1'b0);
    check("nom_busy", busy, 1'b0);
    check_n("nom_sb_drained", sb.size(), 0);

    // Run control
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_in_run_run", run, 1'b1);
    check("start_in_run_cfg", cfg, 1'b0);
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check_idle("stop");
    tick();
    check_idle("after_stop");

    // Backpressure
    bp_mode = 1'b1;
    do_start();
    load_all();
    wait_last();
    bp_mode = 1'b0;
    check_n("bp_sb_drained", sb.size(), 0);
    cfg_ready = 1'b1;
    tick();
    cfg_ready = 1'b0;
    check("bp_run", run, 1'b1);
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // s_tlast on the second word
    do_start();
    send_word(0, 1'b0, 1'b1);
    send_word(1, 1'b1, 1'b0);
    check("early_last_err",    err,             1'b1);
    check("early_last_cfg",    cfg,             1'b0);
    check("early_last_mvalid", bus_if.m_tvalid, 1'b0);
    check_n("early_last_sb", sb.size(), 0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_idle("clear1");

    // Final word without s_tlast
    do_start();
    send_word(0, 1'b0, 1'b1);
    send_word(1, 1'b0, 1'b1);
    send_word(2, 1'b0, 1'b0);
    check("no_last_err",    err,             1'b1);
    check("no_last_cfg",    cfg,             1'b0);
    check("no_last_mvalid", bus_if.m_tvalid, 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_idle("clear2");

    // Timeout: err rises on the 15th edge after the final bit
    do_start();
    load_all();
    wait_last();
    repeat (14) tick();
    check("pre_timeout_err", err, 1'b0);
    check("pre_timeout_cfg", cfg, 1'b1);
    tick();
    check("timeout_err",  err,  1'b1);
    check("timeout_cfg",  cfg,  1'b0);
    check("timeout_busy", busy, 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_idle("clear3");

    // cfg_ready on the timeout cycle wins
    do_start();
    load_all();
    wait_last();
    repeat (14) tick();
    check("race_pre_err", err, 1'b0);
    cfg_ready = 1'b1;
    tick();
    cfg_ready = 1'b0;
    check("race_run",  run,  1'b1);
    check("race_done", done, 1'b1);
    check("race_err",  err,  1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // Asynchronous reset after nine bits
    do_start();
    base = bits_seen;
    send_word(0, 1'b0, 1'b1);
    send_word(1, 1'b0, 1'b1);
    n = 0;
    while (bits_seen < base + 9 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check_n("bits_before_reset", bits_seen - base, 9);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    sb.delete();
    #1;
    rst_n = 1'b1;
    tick();
    check_idle("post_rst");
    do_start();
    load_all();
    wait_last();
    cfg_ready = 1'b1;
    tick();
    cfg_ready = 1'b0;
    check("post_rst_run", run, 1'b1);
    check("post_rst_cfg", cfg, 1'b0);
    check_n("post_rst_sb", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
